// File: rtl/cmd_exec_sched_if.sv
// Command bus between the command-memory writer and the scheduler.
// The writer strobes DATA_WR with the fields; the scheduler answers with REQ_COMM.
interface cmd_exec_sched_if;
   logic        DATA_WR;
   logic [63:0] TIME_START_z;
   logic [15:0] N_impuls_z;
   logic [31:0] Interval_Tp_z;
   logic        REQ_COMM;

   modport master (
      output DATA_WR,
      output TIME_START_z,
      output N_impuls_z,
      output Interval_Tp_z,
      input  REQ_COMM
   );

   modport slave (
      input  DATA_WR,
      input  TIME_START_z,
      input  N_impuls_z,
      input  Interval_Tp_z,
      output REQ_COMM
   );
endinterface

// File: rtl/cmd_exec_sched.sv
// Command execution scheduler: waits for TIME_START, then emits START and
// N impulses spaced by Interval_Tp; requests the next command when done.
module cmd_exec_sched #(
   parameter int unsigned REQ_GAP     = 48,
   parameter logic [63:0] LATE_MARGIN = 64'd0
) (
   input  logic            CLK,
   input  logic            rst,
   input  logic [63:0]     TIME,
   input  logic            SYS_TIME_UPDATE,
   cmd_exec_sched_if.slave cmd,
   output logic            START,
   output logic            IMP,
   output logic [15:0]     IMP_IDX,
   output logic            BUSY,
   output logic            LATE,
   output logic            ABORT
);

   localparam int GW = $clog2(REQ_GAP + 2);
   localparam logic [GW-1:0] GAP_MAX = GW'(REQ_GAP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_d;

   logic [63:0]   t_reg;
   logic [2:0]    upd_sync;
   logic          upd_edge;

   logic [63:0]   t_start;
   logic [63:0]   next_t;
   logic [15:0]   n_q;
   logic [15:0]   k_q;
   logic [31:0]   tp_q;

   logic          sh_vld;
   logic [63:0]   sh_t;
   logic [15:0]   sh_n;
   logic [31:0]   sh_tp;

   logic [GW-1:0] gap;
   logic          gap_full;
   logic          req_q;

   logic [15:0]   wr_n;
   logic [31:0]   wr_tp;
   logic          wr_late;
   logic          sh_late;
   logic          start_hit;
   logic          imp_hit;
   logic          run_end;

   logic          req_d;
   logic          start_d;
   logic          imp_d;
   logic [15:0]   idx_d;
   logic          late_d;
   logic          abort_d;
   logic          ld_wr;
   logic          ld_sh;
   logic          go_run;
   logic          imp_adv;
   logic          sh_wr;
   logic          sh_clr;
   logic          gap_clr;

   assign upd_edge  = upd_sync[1] & ~upd_sync[2];
   assign wr_n      = (cmd.N_impuls_z == 16'd0) ? 16'd1 : cmd.N_impuls_z;
   assign wr_tp     = (cmd.Interval_Tp_z == 32'd0) ? 32'd1 : cmd.Interval_Tp_z;
   assign wr_late   = cmd.TIME_START_z <= t_reg + LATE_MARGIN;
   assign sh_late   = sh_t <= t_reg + LATE_MARGIN;
   assign start_hit = t_reg >= t_start;
   assign imp_hit   = t_reg >= next_t;
   assign run_end   = k_q == n_q;
   assign gap_full  = gap == GAP_MAX;
   assign cmd.REQ_COMM = req_q;

   // State register.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // Next state and strobe decisions; abort beats compare beats DATA_WR.
   always_comb begin
      state_d = state;
      req_d   = 1'b0;
      start_d = 1'b0;
      imp_d   = 1'b0;
      idx_d   = 16'd0;
      late_d  = 1'b0;
      abort_d = 1'b0;
      ld_wr   = 1'b0;
      ld_sh   = 1'b0;
      go_run  = 1'b0;
      imp_adv = 1'b0;
      sh_wr   = 1'b0;
      sh_clr  = 1'b0;
      gap_clr = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd.DATA_WR) begin
               if (wr_late) begin
                  late_d  = 1'b1;
                  gap_clr = 1'b1;
               end else begin
                  ld_wr   = 1'b1;
                  state_d = S_ARMED;
               end
            end else if (gap_full) begin
               req_d   = 1'b1;
               gap_clr = 1'b1;
            end
         end
         S_ARMED: begin
            if (upd_edge) begin
               abort_d = 1'b1;
               sh_clr  = 1'b1;
               gap_clr = 1'b1;
               state_d = S_IDLE;
            end else if (start_hit) begin
               start_d = 1'b1;
               imp_d   = 1'b1;
               go_run  = 1'b1;
               sh_wr   = cmd.DATA_WR;
               state_d = S_RUN;
            end else if (cmd.DATA_WR) begin
               if (wr_late) begin
                  late_d  = 1'b1;
                  gap_clr = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ld_wr = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (upd_edge) begin
               abort_d = 1'b1;
               sh_clr  = 1'b1;
               gap_clr = 1'b1;
               state_d = S_IDLE;
            end else begin
               sh_wr = cmd.DATA_WR;
               if (run_end) begin
                  state_d = S_DONE;
               end else if (imp_hit) begin
                  imp_d   = 1'b1;
                  idx_d   = k_q;
                  imp_adv = 1'b1;
               end
            end
         end
         S_DONE: begin
            sh_clr = 1'b1;
            if (cmd.DATA_WR) begin
               if (wr_late) begin
                  late_d  = 1'b1;
                  gap_clr = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ld_wr   = 1'b1;
                  state_d = S_ARMED;
               end
            end else if (sh_vld) begin
               if (sh_late) begin
                  late_d  = 1'b1;
                  gap_clr = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ld_sh   = 1'b1;
                  state_d = S_ARMED;
               end
            end else begin
               req_d   = 1'b1;
               gap_clr = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register system time and synchronize the time re-set level.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         t_reg    <= 64'd0;
         upd_sync <= 3'd0;
      end else begin
         t_reg    <= TIME;
         upd_sync <= {upd_sync[1:0], SYS_TIME_UPDATE};
      end
   end

   // Active command and impulse schedule.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         t_start <= 64'd0;
         n_q     <= 16'd1;
         tp_q    <= 32'd1;
         next_t  <= 64'd0;
         k_q     <= 16'd0;
      end else begin
         if (ld_wr) begin
            t_start <= cmd.TIME_START_z;
            n_q     <= wr_n;
            tp_q    <= wr_tp;
         end else if (ld_sh) begin
            t_start <= sh_t;
            n_q     <= sh_n;
            tp_q    <= sh_tp;
         end
         if (go_run) begin
            next_t <= t_start + {32'd0, tp_q};
            k_q    <= 16'd1;
         end else if (imp_adv) begin
            next_t <= next_t + {32'd0, tp_q};
            k_q    <= k_q + 16'd1;
         end
      end
   end

   // One-deep shadow for a command arriving while a burst is in flight.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         sh_vld <= 1'b0;
         sh_t   <= 64'd0;
         sh_n   <= 16'd1;
         sh_tp  <= 32'd1;
      end else if (sh_clr) begin
         sh_vld <= 1'b0;
      end else if (sh_wr) begin
         sh_vld <= 1'b1;
         sh_t   <= cmd.TIME_START_z;
         sh_n   <= wr_n;
         sh_tp  <= wr_tp;
      end
   end

   // Saturating spacing counter between REQ_COMM pulses.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst)           gap <= GAP_MAX;
      else if (gap_clr)  gap <= '0;
      else if (!gap_full) gap <= gap + GW'(1);
   end

   // Registered strobes and status.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         req_q   <= 1'b0;
         START   <= 1'b0;
         IMP     <= 1'b0;
         IMP_IDX <= 16'd0;
         BUSY    <= 1'b0;
         LATE    <= 1'b0;
         ABORT   <= 1'b0;
      end else begin
         req_q <= req_d;
         START <= start_d;
         IMP   <= imp_d;
         if (imp_d) IMP_IDX <= idx_d;
         BUSY  <= (state_d == S_ARMED) || (state_d == S_RUN);
         LATE  <= late_d;
         ABORT <= abort_d;
      end
   end

endmodule

// File: tb/tb_cmd_exec_sched.sv
// Bench for cmd_exec_sched: directed scenarios plus random traffic,
// every cycle compared with a schedule-level reference model.
module tb_cmd_exec_sched;

   localparam int GAP = 48;
   localparam longint unsigned MARGIN = 0;
   localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

   logic        CLK;
   logic        rst;
   logic [63:0] TIME;
   logic        SYS_TIME_UPDATE;
   logic        START, IMP, BUSY, LATE, ABORT;
   logic [15:0] IMP_IDX;

   cmd_exec_sched_if bus ();

   cmd_exec_sched #(.REQ_GAP(GAP), .LATE_MARGIN(MARGIN)) dut (
      .CLK(CLK),
      .rst(rst),
      .TIME(TIME),
      .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
      .cmd(bus),
      .START(START),
      .IMP(IMP),
      .IMP_IDX(IMP_IDX),
      .BUSY(BUSY),
      .LATE(LATE),
      .ABORT(ABORT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      longint unsigned t;
      int unsigned     n;
      longint unsigned tp;
   } cmd_t;

   int n_vec = 0;
   int n_err = 0;

   // reference model
   int              md;
   cmd_t            cur;
   cmd_t            shq[$];
   int unsigned     emitted;
   int              mg;
   bit              gclr;
   longint unsigned mt;
   bit [2:0]        sy;
   bit e_req, e_start, e_imp, e_busy, e_late, e_abort;
   int unsigned     e_idx;

   // stimulus / observation
   longint unsigned tnow;
   longint unsigned tsamp;
   int              upd_hold;
   int              tick_no;
   int              imp_cnt, start_cnt, late_cnt, abort_cnt, busy_cnt;
   int              last_imp, late_tick, abort_tick;
   longint unsigned imp_ts[$];
   longint unsigned start_ts[$];
   int              imp_ix[$];
   int              req_q[$];

   task automatic chk(input string tag, input longint unsigned got,
                      input longint unsigned exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      md = M_IDLE;
      shq.delete();
      emitted = 0;
      mg = GAP;
      mt = 0;
      sy = 3'b000;
      e_req = 0; e_start = 0; e_imp = 0;
      e_busy = 0; e_late = 0; e_abort = 0;
      e_idx = 0;
   endtask

   task automatic m_load(input cmd_t c, input longint unsigned t);
      if (c.n == 0) c.n = 1;
      if (c.tp == 0) c.tp = 1;
      if (c.t <= t + MARGIN) begin
         e_late = 1;
         gclr = 1;
         md = M_IDLE;
      end else begin
         cur = c;
         md = M_ARMED;
      end
   endtask

   task automatic m_abort();
      e_abort = 1;
      shq.delete();
      gclr = 1;
      md = M_IDLE;
   endtask

   task automatic m_step();
      bit              ue, dw;
      longint unsigned t;
      cmd_t            w, c;
      if (rst) begin
         m_reset();
         return;
      end
      ue = sy[1] & ~sy[2];
      t = mt;
      dw = bus.DATA_WR;
      w.t = bus.TIME_START_z;
      w.n = bus.N_impuls_z;
      w.tp = bus.Interval_Tp_z;
      e_req = 0; e_start = 0; e_imp = 0; e_late = 0; e_abort = 0;
      gclr = 0;
      case (md)
         M_IDLE: begin
            if (dw) m_load(w, t);
            else if (mg == GAP) begin
               e_req = 1;
               gclr = 1;
            end
         end
         M_ARMED: begin
            if (ue) m_abort();
            else if (t >= cur.t) begin
               e_start = 1;
               e_imp = 1;
               e_idx = 0;
               emitted = 1;
               md = M_RUN;
               if (dw) begin
                  shq.delete();
                  shq.push_back(w);
               end
            end else if (dw) m_load(w, t);
         end
         M_RUN: begin
            if (ue) m_abort();
            else begin
               if (dw) begin
                  shq.delete();
                  shq.push_back(w);
               end
               if (emitted == cur.n) md = M_DONE;
               else if (t >= cur.t + 64'(emitted) * cur.tp) begin
                  e_imp = 1;
                  e_idx = emitted;
                  emitted++;
               end
            end
         end
         default: begin
            if (dw) begin
               shq.delete();
               m_load(w, t);
            end else if (shq.size() > 0) begin
               c = shq[0];
               shq.delete();
               m_load(c, t);
            end else begin
               shq.delete();
               e_req = 1;
               gclr = 1;
               md = M_IDLE;
            end
         end
      endcase
      if (gclr) mg = 0;
      else if (mg < GAP) mg++;
      e_busy = (md == M_ARMED) || (md == M_RUN);
      mt = TIME;
      sy = {sy[1:0], SYS_TIME_UPDATE};
   endtask

   task automatic clr_obs();
      tick_no = 0;
      imp_cnt = 0; start_cnt = 0; late_cnt = 0; abort_cnt = 0; busy_cnt = 0;
      last_imp = -1; late_tick = -1; abort_tick = -1;
      imp_ts.delete(); start_ts.delete(); imp_ix.delete(); req_q.delete();
   endtask

   task automatic tick();
      @(posedge CLK);
      tsamp = TIME;
      m_step();
      #1;
      tick_no++;
      chk("REQ_COMM", bus.REQ_COMM, e_req);
      chk("START", START, e_start);
      chk("IMP", IMP, e_imp);
      chk("BUSY", BUSY, e_busy);
      chk("LATE", LATE, e_late);
      chk("ABORT", ABORT, e_abort);
      if (e_imp) chk("IMP_IDX", IMP_IDX, e_idx);
      if (IMP) begin
         imp_cnt++;
         last_imp = tick_no;
         imp_ts.push_back(tsamp);
         imp_ix.push_back(int'(IMP_IDX));
      end
      if (START) begin
         start_cnt++;
         start_ts.push_back(tsamp);
      end
      if (LATE) begin
         late_cnt++;
         late_tick = tick_no;
      end
      if (ABORT) begin
         abort_cnt++;
         abort_tick = tick_no;
      end
      if (BUSY) busy_cnt++;
      if (bus.REQ_COMM) req_q.push_back(tick_no);
      bus.DATA_WR = 1'b0;
      TIME = tnow;
      tnow = tnow + 1;
      SYS_TIME_UPDATE = (upd_hold > 0);
      if (upd_hold > 0) upd_hold--;
   endtask

   task automatic settle(input longint unsigned t);
      tnow = t;
      tick();
      tick();
   endtask

   task automatic send(input longint unsigned ts, input int n, input int tp);
      bus.DATA_WR = 1'b1;
      bus.TIME_START_z = ts;
      bus.N_impuls_z = 16'(n);
      bus.Interval_Tp_z = 32'(tp);
   endtask

   initial begin
      bit found;
      rst = 1'b1;
      TIME = 64'd0;
      SYS_TIME_UPDATE = 1'b0;
      bus.DATA_WR = 1'b0;
      bus.TIME_START_z = 64'd0;
      bus.N_impuls_z = 16'd0;
      bus.Interval_Tp_z = 32'd0;
      tnow = 0;
      upd_hold = 0;
      m_reset();
      clr_obs();

      // reset state, then idle request cadence
      repeat (3) tick();
      rst = 1'b0;
      clr_obs();
      repeat (100) tick();
      chk("idle_req_count", req_q.size(), 3);
      chk("idle_req_first", req_q[0], 1);
      chk("idle_req_second", req_q[1], 50);
      chk("idle_req_third", req_q[2], 99);

      // three-impulse burst at 1000, period 100
      settle(500);
      clr_obs();
      send(1000, 3, 100);
      repeat (720) tick();
      chk("burst_start_count", start_cnt, 1);
      chk("burst_start_time", start_ts[0], 1001);
      chk("burst_imp_count", imp_cnt, 3);
      chk("burst_imp0_time", imp_ts[0], 1001);
      chk("burst_imp1_time", imp_ts[1], 1101);
      chk("burst_imp2_time", imp_ts[2], 1201);
      chk("burst_imp1_idx", imp_ix[1], 1);
      chk("burst_imp2_idx", imp_ix[2], 2);
      chk("burst_req_count", req_q.size(), 1);
      chk("burst_req_tick", req_q[0], last_imp + 2);

      // late command
      settle(500);
      clr_obs();
      send(400, 2, 5);
      repeat (60) tick();
      chk("late_count", late_cnt, 1);
      chk("late_tick", late_tick, 1);
      chk("late_no_start", start_cnt, 0);
      chk("late_no_busy", busy_cnt, 0);
      chk("late_req_tick", req_q[0], 50);

      // time re-set during RUN
      settle(700);
      clr_obs();
      send(720, 5, 10);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (IMP && IMP_IDX == 16'd1) begin
            found = 1;
            break;
         end
      end
      chk("abort_k1_seen", found, 1);
      upd_hold = 4;
      tnow = 0;
      clr_obs();
      repeat (60) tick();
      chk("abort_count", abort_cnt, 1);
      chk("abort_tick", abort_tick, 4);
      chk("abort_no_imp", imp_cnt, 0);
      chk("abort_busy_low", BUSY, 0);
      chk("abort_req_count", req_q.size(), 1);
      chk("abort_req_tick", req_q[0], abort_tick + 49);

      // two commands into the shadow while running
      settle(3000);
      clr_obs();
      send(3020, 4, 50);
      repeat (30) tick();
      send(5000, 2, 1000);
      tick();
      repeat (5) tick();
      send(6000, 2, 1000);
      tick();
      for (int i = 0; i < 4000 && tsamp < 6050; i++) tick();
      chk("shadow_start_count", start_cnt, 2);
      chk("shadow_start0", start_ts[0], 3021);
      chk("shadow_start1", start_ts[1], 6001);
      chk("shadow_imp_count", imp_cnt, 5);
      chk("shadow_no_req", req_q.size(), 0);
      chk("shadow_busy", BUSY, 1);
      for (int i = 0; i < 1200 && tsamp < 7010; i++) tick();

      // zero count and zero period
      settle(1990);
      clr_obs();
      send(2000, 0, 0);
      repeat (40) tick();
      chk("n0_start_time", start_ts[0], 2001);
      chk("n0_imp_count", imp_cnt, 1);
      chk("n0_imp_idx", imp_ix[0], 0);
      chk("n0_req_tick", req_q[0], last_imp + 2);

      // random traffic with a mid-run reset
      settle(300);
      for (int i = 0; i < 5000; i++) begin
         if (i == 2500) rst = 1'b1;
         if (i == 2502) rst = 1'b0;
         if (!rst && $urandom_range(0, 29) == 0)
            send(tnow + 64'($urandom_range(0, 80)) - 8,
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 15)));
         if (!rst && upd_hold == 0 && $urandom_range(0, 399) == 0) begin
            upd_hold = int'($urandom_range(2, 5));
            tnow = 64'($urandom_range(200, 2000));
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
